// File: rtl/dc_ipu_addr_pkg.sv
// Shared types and default widths for the IPU address-compute frame scheduler.
package dc_ipu_addr_pkg;

  localparam int unsigned TEX_SIZE_WIDTH_DEF = 12;
  localparam int unsigned IMG_SIZE_WIDTH_DEF = 12;

  typedef enum logic {
    AXIS_X = 1'b0,
    AXIS_Y = 1'b1
  } axis_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROW,
    ST_COL,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/dc_ipu_addr_seq_ctr.sv
// Enabled up-counter with synchronous clear and a "last" flag against a limit.
module dc_ipu_addr_seq_ctr
  import dc_ipu_addr_pkg::*;
#(
  parameter int unsigned WIDTH = IMG_SIZE_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == limit);

endmodule

// File: rtl/dc_ipu_addr_seq.sv
// Frame scheduler: one Y request per output row, then one X request per pixel.
// Optional DC_IPU_ADDR_SEQ_STALL_CNT_EN adds a saturating 32-bit stall counter.
module dc_ipu_addr_seq
  import dc_ipu_addr_pkg::*;
#(
  parameter int unsigned TEX_SIZE_WIDTH = TEX_SIZE_WIDTH_DEF,
  parameter int unsigned IMG_SIZE_WIDTH = IMG_SIZE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      clr,
  input  logic                      start,
  input  logic [IMG_SIZE_WIDTH-1:0] cfg_img_w,
  input  logic [IMG_SIZE_WIDTH-1:0] cfg_img_h,
  input  logic [TEX_SIZE_WIDTH-1:0] cfg_tex_w,
  input  logic [TEX_SIZE_WIDTH-1:0] cfg_tex_h,
  output logic                      busy,
  output logic                      done,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IMG_SIZE_WIDTH-1:0] out_img_size,
  output logic [TEX_SIZE_WIDTH-1:0] out_tex_size,
  output logic [IMG_SIZE_WIDTH-1:0] out_x,
  output logic                      out_axis,
  output logic                      out_eol,
  output logic                      out_eof
`ifdef DC_IPU_ADDR_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  seq_state_t                state_q, state_d;
  logic [IMG_SIZE_WIDTH-1:0] img_w_q, img_h_q;
  logic [TEX_SIZE_WIDTH-1:0] tex_w_q, tex_h_q;
  logic                      empty_q;
  logic                      accept, ctr_clr, col_hs;
  logic [IMG_SIZE_WIDTH-1:0] row, col;
  logic                      row_last, col_last;
  logic                      is_row;

  assign accept  = (state_q == ST_IDLE) && start && !clr;
  assign ctr_clr = clr || accept;
  assign col_hs  = (state_q == ST_COL) && out_ready;

  dc_ipu_addr_seq_ctr #(.WIDTH(IMG_SIZE_WIDTH)) u_col_ctr (
    .clk    (clk),
    .nreset (nreset),
    .clr    (ctr_clr || (col_hs && col_last)),
    .en     (col_hs),
    .limit  (img_w_q - 1'b1),
    .cnt    (col),
    .last   (col_last)
  );

  dc_ipu_addr_seq_ctr #(.WIDTH(IMG_SIZE_WIDTH)) u_row_ctr (
    .clk    (clk),
    .nreset (nreset),
    .clr    (ctr_clr),
    .en     (col_hs && col_last),
    .limit  (img_h_q - 1'b1),
    .cnt    (row),
    .last   (row_last)
  );

  // A zero-size frame still passes through ROW for one cycle, with valid
  // suppressed, so busy pulses once and done lands two cycles after start.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      img_w_q <= '0;
      img_h_q <= '0;
      tex_w_q <= '0;
      tex_h_q <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        img_w_q <= cfg_img_w;
        img_h_q <= cfg_img_h;
        tex_w_q <= cfg_tex_w;
        tex_h_q <= cfg_tex_h;
        empty_q <= (cfg_img_w == '0) || (cfg_img_h == '0);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_ROW;
      ST_ROW: begin
        if (clr)            state_d = ST_IDLE;
        else if (empty_q)   state_d = ST_DONE;
        else if (out_ready) state_d = ST_COL;
      end
      ST_COL: begin
        if (clr)                  state_d = ST_IDLE;
        else if (col_hs && col_last) state_d = row_last ? ST_DONE : ST_ROW;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    is_row       = (state_q == ST_ROW);
    out_valid    = (is_row && !empty_q) || (state_q == ST_COL);
    busy         = is_row || (state_q == ST_COL);
    done         = (state_q == ST_DONE);
    out_axis     = AXIS_X;
    out_x        = '0;
    out_img_size = '0;
    out_tex_size = '0;
    if (out_valid) begin
      out_axis     = is_row ? AXIS_Y : AXIS_X;
      out_x        = is_row ? row : col;
      out_img_size = is_row ? img_h_q : img_w_q;
      out_tex_size = is_row ? tex_h_q : tex_w_q;
    end
    out_eol = (state_q == ST_COL) && col_last;
    out_eof = out_eol && row_last;
  end

`ifdef DC_IPU_ADDR_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stall_cnt <= '0;
    end else if (ctr_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
